// File: rtl/dna_stream_tx_pkg.sv
// -----------------------------------------------------------------------------
// dna_pkg
// Shared definitions for the device-DNA stream transmitter:
//   - default DNA width and CRC-8 polynomial
//   - controller state encoding
//   - crc8_byte(): one CRC-8 update step for a full byte (MSB first,
//     init/no reflection/no final XOR are handled by the caller)
// -----------------------------------------------------------------------------
package dna_pkg;

    localparam int         DNA_LENGTH_DEF = 96;
    localparam logic [7:0] CRC8_POLY      = 8'h07;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CRC  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Fold one byte into the running CRC, unrolled over its 8 bits.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly = CRC8_POLY);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dna_stream_tx_if.sv
// -----------------------------------------------------------------------------
// dna_stream_tx_if
// Byte stream towards the slow-control readout FIFO.
//   tx_data  : stream byte                 (master -> slave)
//   tx_valid : tx_data valid               (master -> slave)
//   tx_last  : marks the trailing CRC byte (master -> slave)
//   tx_ready : downstream accept           (slave  -> master)
// A byte moves on every clock edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface dna_stream_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/dna_stream_tx_byte_mux.sv
// -----------------------------------------------------------------------------
// dna_byte_mux
// Combinational byte selector for the DNA stream.
//   dna_i  : latched DNA vector, byte 0 is the most significant byte
//   crc_i  : CRC byte, selected when idx_i == NBYTES
//   idx_i  : byte index 0..NBYTES
//   byte_o : selected byte
// -----------------------------------------------------------------------------
module dna_byte_mux #(
    parameter int DNA_LENGTH = 96,
    parameter int NBYTES     = DNA_LENGTH / 8,
    parameter int IDX_W      = $clog2(NBYTES + 1)
) (
    input  logic [DNA_LENGTH-1:0] dna_i,
    input  logic [7:0]            crc_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [7:0]            byte_o
);

    always_comb begin
        byte_o = crc_i;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_i == IDX_W'(i)) begin
                byte_o = dna_i[DNA_LENGTH-1-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/dna_stream_tx.sv
// -----------------------------------------------------------------------------
// dna_stream_tx
// Waits for the device DNA to become final, latches it, computes a CRC-8 over
// its bytes and streams DNA bytes + CRC into the readout FIFO.
//   clock       : system clock
//   reset       : synchronous, active-high
//   dna         : DNA from the reader, all-zero until its read completes
//   rearm       : pulse, re-streams the latched value (honoured only in DONE)
//   tx          : byte stream (master side)
//   dna_latched : captured DNA
//   dna_valid   : latch and CRC complete
//   dna_zero    : latch was forced by the timeout with a zero value
//   crc         : CRC-8 over the latched bytes
//   busy        : high in WAIT, CRC and SEND; low while reset is held
// -----------------------------------------------------------------------------
module dna_stream_tx
    import dna_pkg::*;
#(
    parameter int         DNA_LENGTH = DNA_LENGTH_DEF,
    parameter int         TIMEOUT    = 256,
    parameter logic [7:0] CRC_POLY   = CRC8_POLY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DNA_LENGTH-1:0] dna,
    input  logic                  rearm,
    dna_stream_tx_if.master       tx,
    output logic [DNA_LENGTH-1:0] dna_latched,
    output logic                  dna_valid,
    output logic                  dna_zero,
    output logic [7:0]            crc,
    output logic                  busy
);

    localparam int NBYTES = DNA_LENGTH / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int CNT_W  = $clog2(TIMEOUT);

    state_e                state_q, state_d;
    logic [DNA_LENGTH-1:0] smp_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            crc_acc_q, crc_acc_d;
    logic [7:0]            crc_q, crc_d;
    logic [DNA_LENGTH-1:0] latched_q, latched_d;
    logic                  valid_q, valid_d;
    logic                  zero_q, zero_d;

    logic [7:0]            mux_byte;
    logic [7:0]            crc_step;
    logic                  sending;

    // The same selector feeds the CRC walk (idx < NBYTES) and the stream.
    dna_byte_mux #(
        .DNA_LENGTH (DNA_LENGTH),
        .NBYTES     (NBYTES),
        .IDX_W      (IDX_W)
    ) u_mux (
        .dna_i  (latched_q),
        .crc_i  (crc_q),
        .idx_i  (idx_q),
        .byte_o (mux_byte)
    );

    assign crc_step = crc8_byte(crc_acc_q, mux_byte, CRC_POLY);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        crc_acc_d = crc_acc_q;
        crc_d     = crc_q;
        latched_d = latched_q;
        valid_d   = valid_q;
        zero_d    = zero_q;

        unique case (state_q)
            ST_WAIT: begin
                // Saturating counter; a changing non-zero DNA does not clear it.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if ((dna != '0) && (dna == smp_q)) begin
                    latched_d = dna;
                    zero_d    = 1'b0;
                    idx_d     = '0;
                    crc_acc_d = 8'h00;
                    state_d   = ST_CRC;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    latched_d = '0;
                    zero_d    = 1'b1;
                    idx_d     = '0;
                    crc_acc_d = 8'h00;
                    state_d   = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_acc_d = crc_step;
                if (idx_q == IDX_W'(NBYTES - 1)) begin
                    crc_d   = crc_step;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SEND: begin
                // tx_valid is high for the whole of SEND, so ready alone
                // means a transfer on this edge.
                if (tx.tx_ready) begin
                    if (idx_q == IDX_W'(NBYTES)) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (rearm) begin
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_WAIT;
            smp_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            crc_acc_q <= 8'h00;
            crc_q     <= 8'h00;
            latched_q <= '0;
            valid_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= dna;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            crc_acc_q <= crc_acc_d;
            crc_q     <= crc_d;
            latched_q <= latched_d;
            valid_q   <= valid_d;
            zero_q    <= zero_d;
        end
    end

    assign sending     = (state_q == ST_SEND);
    assign tx.tx_valid = sending;
    assign tx.tx_data  = sending ? mux_byte : 8'h00;
    assign tx.tx_last  = sending && (idx_q == IDX_W'(NBYTES));

    assign dna_latched = latched_q;
    assign dna_valid   = valid_q;
    assign dna_zero    = zero_q;
    assign crc         = crc_q;
    assign busy        = (state_q != ST_DONE) && !reset;

endmodule

// File: tb/tb_dna_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_dna_stream_tx
// Directed bench for dna_stream_tx with a bit-serial CRC-8 reference.
// -----------------------------------------------------------------------------
module tb_dna_stream_tx;

    localparam int NB = 12;
    localparam logic [95:0] VEC = 96'h0123456789ABCDEFFEDCBA98;

    logic        clock;
    logic        reset;
    logic [95:0] dna;
    logic        rearm;
    logic [95:0] dna_latched;
    logic        dna_valid;
    logic        dna_zero;
    logic [7:0]  crc;
    logic        busy;

    dna_stream_tx_if txif();

    dna_stream_tx #(
        .DNA_LENGTH (96),
        .TIMEOUT    (256),
        .CRC_POLY   (8'h07)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dna         (dna),
        .rearm       (rearm),
        .tx          (txif),
        .dna_latched (dna_latched),
        .dna_valid   (dna_valid),
        .dna_zero    (dna_zero),
        .crc         (crc),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_b [NB+1];
    logic [7:0] exp_crc;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bit-serial CRC-8 (poly 0x07, init 0) over the vector, MSB first.
    function automatic logic [7:0] ref_crc(input logic [95:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int b = 95; b >= 0; b--) begin
            fb = c[7] ^ v[b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic load_exp(input logic [95:0] v);
        for (int i = 0; i < NB; i++) exp_b[i] = v[95-8*i -: 8];
        exp_crc   = ref_crc(v);
        exp_b[NB] = exp_crc;
    endtask

    task automatic apply_reset(input logic [95:0] d_after);
        reset = 1'b1;
        rearm = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        dna   = d_after;
    endtask

    // Called right after the latch edge: dna_valid must rise on the 12th edge.
    task automatic expect_crc_done(input string tag);
        repeat (NB - 1) tick();
        check({tag, "_dv_early"}, dna_valid, 1'b0);
        tick();
        check({tag, "_dv"}, dna_valid, 1'b1);
        check({tag, "_crc"}, crc, exp_crc);
        check({tag, "_send_valid"}, txif.tx_valid, 1'b1);
    endtask

    // mode 0: ready always high; mode 1: ready toggles with a 5-cycle stall at
    // byte 6; mode 2: ready high with a rearm pulse in the middle of the stream.
    task automatic stream(input string tag, input int mode, input int stop_at);
        int         n = 0;
        int         cyc = 0;
        int         stall_left = 5;
        logic       tog = 1'b1;
        logic       stalled = 1'b0;
        logic       pulsed = 1'b0;
        logic       rdy;
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        while (n < stop_at && cyc < 300) begin
            if (stalled) begin
                check({tag, "_hold_data"}, txif.tx_data, pd);
                check({tag, "_hold_last"}, txif.tx_last, pl);
            end
            rearm = 1'b0;
            if (mode == 1) begin
                if (n == 6 && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = tog;
                    tog = ~tog;
                end
            end else begin
                rdy = 1'b1;
            end
            if (mode == 2 && n == 4 && !pulsed) begin
                rearm  = 1'b1;
                pulsed = 1'b1;
            end
            txif.tx_ready = rdy;
            check({tag, "_valid"}, txif.tx_valid, 1'b1);
            if (rdy && txif.tx_valid) begin
                check({tag, "_data"}, txif.tx_data, exp_b[n]);
                check({tag, "_last"}, txif.tx_last, (n == NB));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = txif.tx_valid;
                pd      = txif.tx_data;
                pl      = txif.tx_last;
            end
            tick();
            cyc++;
        end
        rearm         = 1'b0;
        txif.tx_ready = 1'b1;
        check({tag, "_count"}, n, stop_at);
        if (mode != 1) check({tag, "_cycles"}, cyc, stop_at);
        if (stop_at == NB + 1) begin
            check({tag, "_valid_drop"}, txif.tx_valid, 1'b0);
            check({tag, "_idle"}, busy, 1'b0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        dna           = '0;
        rearm         = 1'b0;
        txif.tx_ready = 1'b1;

        // Reset values
        apply_reset(96'h0);
        reset = 1'b1;
        tick();
        check("rst_tx_valid", txif.tx_valid, 1'b0);
        check("rst_tx_data", txif.tx_data, 8'h00);
        check("rst_tx_last", txif.tx_last, 1'b0);
        check("rst_latched", dna_latched, 96'h0);
        check("rst_dv", dna_valid, 1'b0);
        check("rst_zero", dna_zero, 1'b0);
        check("rst_crc", crc, 8'h00);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // DNA appears after 98 cycles, back-to-back stream
        load_exp(VEC);
        repeat (98) tick();
        check("wait_busy", busy, 1'b1);
        check("wait_dv", dna_valid, 1'b0);
        dna = VEC;
        tick();
        check("first_sample_nolatch", dna_latched, 96'h0);
        tick();
        check("latch_value", dna_latched, VEC);
        check("latch_zero", dna_zero, 1'b0);
        expect_crc_done("main");
        stream("main", 0, NB + 1);
        check("main_zero", dna_zero, 1'b0);

        // Reset while byte 7 is pending, then a fresh latch and stream
        apply_reset(VEC);
        tick();
        tick();
        check("r2_latch", dna_latched, VEC);
        expect_crc_done("r2");
        stream("pre_rst", 0, 7);
        check("pend7_valid", txif.tx_valid, 1'b1);
        check("pend7_data", txif.tx_data, exp_b[7]);
        reset = 1'b1;
        tick();
        check("midrst_valid", txif.tx_valid, 1'b0);
        check("midrst_dv", dna_valid, 1'b0);
        check("midrst_zero", dna_zero, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        check("r3_latch", dna_latched, VEC);
        expect_crc_done("r3");
        stream("post_rst", 0, NB + 1);

        // Rearm in DONE, with a rearm pulse during the replay that must be ignored
        check("done_dv", dna_valid, 1'b1);
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        check("rearm_valid", txif.tx_valid, 1'b1);
        check("rearm_busy", busy, 1'b1);
        stream("rearm", 2, NB + 1);
        check("rearm_crc", crc, exp_crc);

        // Glitching DNA 1 -> 2 -> 2 latches 2; later changes are ignored
        apply_reset(96'h1);
        load_exp(96'h2);
        tick();
        dna = 96'h2;
        tick();
        check("glitch_nolatch", dna_latched, 96'h0);
        tick();
        check("glitch_latch", dna_latched, 96'h2);
        dna = VEC;
        expect_crc_done("glitch");
        stream("stall", 1, NB + 1);
        check("glitch_hold", dna_latched, 96'h2);

        // DNA stays zero: timeout latch at counter value 255
        apply_reset(96'h0);
        load_exp(96'h0);
        repeat (255) tick();
        check("to_early_zero", dna_zero, 1'b0);
        check("to_early_busy", busy, 1'b1);
        tick();
        check("to_zero", dna_zero, 1'b1);
        check("to_latched", dna_latched, 96'h0);
        expect_crc_done("to");
        stream("to", 0, NB + 1);
        check("to_zero_hold", dna_zero, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dna_stream_tx.md
Name: dna_stream_tx

Overview:
- Consumes the 96-bit device DNA bus from the DNA reader stage. That bus is all-zero until the read completes, then holds the value.
- Detects when the DNA value is final, latches it and appends a CRC-8.
- Streams the DNA bytes plus CRC over a valid/ready byte interface into the slow-control readout FIFO.
- Also holds the latched value and status flags for the register file.

Parameters:
- DNA_LENGTH, 96, width of incoming DNA; must be a multiple of 8. NBYTES = DNA_LENGTH/8.
- TIMEOUT, 256, cycles after reset to wait for a non-zero DNA before latching zero; must be > DNA_LENGTH+4.
- CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, no reflection, no final XOR.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- dna  in  DNA_LENGTH  DNA from the reader; zero until its read completes.
- rearm  in  1  single-cycle pulse; re-streams the already-latched value.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accept.
- tx_last  out  1  high with the CRC byte.
- dna_latched  out  DNA_LENGTH  captured DNA.
- dna_valid  out  1  high once the latch has occurred.
- dna_zero  out  1  latch occurred by timeout with a zero value.
- crc  out  8  CRC over the latched bytes.
- busy  out  1  high while in WAIT, CRC or SEND.

Behaviour:
- Reset values: all outputs 0. State = WAIT. Timeout counter = 0. Byte index = 0.
- The block is synchronous to clock only. Reset applies on the clock edge and takes priority over every other event.
- WAIT:
  - Register dna each cycle into dna_q; the timeout counter increments and saturates.
  - Latch when dna != 0 and dna == dna_q (stable for 2 consecutive samples). Then dna_latched <= dna, dna_zero <= 0, go to CRC.
  - Else, if the counter reaches TIMEOUT-1: dna_latched <= 0, dna_zero <= 1, go to CRC. This covers the simulation model, where DNA is all-zero.
  - A non-zero but changing dna restarts the stability check only; it does not reset the timeout counter.
- CRC:
  - Process one byte per cycle, MSB byte first, for NBYTES cycles: crc_next = crc8(crc_acc ^ byte).
  - On the last byte: crc <= result, dna_valid <= 1, go to SEND.
  - dna_valid rises exactly NBYTES cycles after the latch edge.
- SEND:
  - tx_valid asserts on the first cycle in SEND.
  - Byte i (i = 0..NBYTES-1) is dna_latched[DNA_LENGTH-1-8i -: 8]. Byte NBYTES is crc, with tx_last = 1.
  - Transfer occurs when tx_valid && tx_ready. The index advances only on a transfer.
  - tx_data and tx_last are held stable while tx_valid && !tx_ready.
  - After the CRC byte transfers: tx_valid <= 0 on the next cycle, go to DONE. No bubble cycles are inserted between bytes when tx_ready stays high.
- DONE:
  - busy = 0. dna_latched, crc and dna_valid are held.
  - rearm -> SEND with index 0; no re-latch and no CRC recompute.
- rearm outside DONE is ignored, including during SEND.
- Changes on dna after the latch are ignored until reset.
- Reset mid-CRC or mid-SEND: abort immediately. tx_valid is 0 in the cycle after the reset edge. dna_valid and dna_zero clear. Detection restarts from WAIT.
- busy = (state != DONE) && !reset-held-state; busy is 0 during reset.

Decomposition:
- Shared package dna_pkg:
  - localparams DNA_LENGTH_DEF = 96 and CRC8_POLY = 8'h07.
  - State enum {WAIT, CRC, SEND, DONE}.
  - Function crc8_byte(crc, data), unrolled over 8 bits.
- One sub-module is natural: dna_byte_mux, which selects byte i of the latched vector, or crc when i == NBYTES, combinationally.

Test Plan:
- DNA 96'h0123456789ABCDEFFEDCBA98 appears 98 cycles after reset; tx_ready = 1.
  - Latch on the 2nd stable sample. dna_valid 12 cycles later.
  - 13 back-to-back bytes 01,23,...,98, then crc matching the crc8 reference model. tx_last only on byte 13. dna_zero = 0.
- dna held at 0 forever -> latch at cycle TIMEOUT-1 = 255. dna_zero = 1, dna_latched = 0, crc = 8'h00. Stream is 12 × 8'h00 then 8'h00 with last.
- tx_ready toggling 1/0 each cycle, and held low for 5 cycles at byte 6 -> tx_data/tx_last stable while stalled. 13 transfers exactly, no byte skipped or duplicated.
- dna glitches 96'h1 -> 96'h2 -> 96'h2 -> latches 96'h2, not 96'h1.
- Reset asserted while byte 7 is pending -> tx_valid 0 and dna_valid 0 the next cycle. With dna stable at its value, a fresh latch and a full 13-byte stream follow.
- rearm pulse in DONE -> identical 13-byte stream with the same crc. rearm pulse during SEND -> no effect on sequence or count.
